// File: rtl/ide_cycle_ctrl_if.sv
// ide_cycle_ctrl_if: bus-decode / IDE connector signals seen by ide_cycle_ctrl.
//   Bus side      : ide_access, AS_n, UDS_n, LDS_n, RW, ADDR16, ADDR12, IDE_IORDY
//   Card side     : IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n, BUF_DIR
//   Status        : dtack (active high, gated by AS_n), iordy_tmo (sticky)
// master modport drives the bus-side inputs; slave modport is the cycle controller.
interface ide_cycle_ctrl_if;
   logic ide_access;
   logic AS_n;
   logic UDS_n;
   logic LDS_n;
   logic RW;
   logic ADDR16;
   logic ADDR12;
   logic IDE_IORDY;
   logic IDE_CS0_n;
   logic IDE_CS1_n;
   logic IDE_IOR_n;
   logic IDE_IOW_n;
   logic ROM_OE_n;
   logic BUF_OE_n;
   logic BUF_DIR;
   logic dtack;
   logic iordy_tmo;

   modport master (
      output ide_access, AS_n, UDS_n, LDS_n, RW, ADDR16, ADDR12, IDE_IORDY,
      input  IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n,
             BUF_DIR, dtack, iordy_tmo
   );

   modport slave (
      input  ide_access, AS_n, UDS_n, LDS_n, RW, ADDR16, ADDR12, IDE_IORDY,
      output IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n,
             BUF_DIR, dtack, iordy_tmo
   );
endinterface

// File: rtl/ide_cycle_ctrl.sv
// ide_cycle_ctrl: sequences 68000 bus cycles hitting the IDE card's 128K window.
//   ADDR16=0 -> boot ROM (reads enable ROM_OE_n, writes acknowledged and dropped)
//   ADDR16=1 -> ATA task file, ADDR12 selects CS1 (1) or CS0 (0), PIO IOR/IOW strobes
//   with programmable setup / active / recovery timing.
// Ports:
//   CLK      : 68000 bus clock, all state on rising edge
//   RESET_n  : asynchronous active-low reset
//   bus      : ide_cycle_ctrl_if.slave (decode inputs, ATA/ROM/buffer controls, dtack, iordy_tmo)
// Optional feature macro: IDE_IORDY_EN (honour IORDY wait states with WAIT_MAX timeout).
module ide_cycle_ctrl #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned ACTIVE_CYC = 3,
   parameter int unsigned RECOV_CYC  = 1,
   parameter int unsigned ROM_WAIT   = 1,
   parameter int unsigned WAIT_MAX   = 64
) (
   input logic             CLK,
   input logic             RESET_n,
   ide_cycle_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACTIVE,
      ST_ROMRD,
      ST_TERM,
      ST_RECOVER
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       ide_q, ide_d;
   logic       a12_q, a12_d;
   logic       rw_q, rw_d;

   logic       cs0_n_q, cs0_n_d;
   logic       cs1_n_q, cs1_n_d;
   logic       ior_n_q, ior_n_d;
   logic       iow_n_q, iow_n_d;
   logic       rom_oe_n_q, rom_oe_n_d;
   logic       buf_oe_n_q, buf_oe_n_d;
   logic       buf_dir_q, buf_dir_d;
   logic       dtack_q, dtack_d;

   logic       start_c;

`ifdef IDE_IORDY_EN
   localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              tmo_q, tmo_d;
`endif

   // A cycle starts when the window is hit with AS_n and at least one data strobe low.
   assign start_c = bus.ide_access & ~bus.AS_n & (~bus.UDS_n | ~bus.LDS_n);

   // Next-state, shared down-counter and registered-output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ide_d   = ide_q;
      a12_d   = a12_q;
      rw_d    = rw_q;
`ifdef IDE_IORDY_EN
      wait_d  = wait_q;
      tmo_d   = tmo_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               ide_d = bus.ADDR16;
               a12_d = bus.ADDR12;
               rw_d  = bus.RW;
               if (bus.ADDR16) begin
                  state_d = ST_SETUP;
                  cnt_d   = 3'(SETUP_CYC);
               end else if (bus.RW) begin
                  if (ROM_WAIT == 0) begin
                     state_d = ST_TERM;
                  end else begin
                     state_d = ST_ROMRD;
                     cnt_d   = 3'(ROM_WAIT);
                  end
               end else begin
                  state_d = ST_TERM;
               end
            end
         end

         ST_SETUP: begin
            if (bus.AS_n) begin
               // Aborted before the strobe: still serve the recovery time on CS.
               if (RECOV_CYC != 0) begin
                  state_d = ST_RECOVER;
                  cnt_d   = 3'(RECOV_CYC);
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (cnt_q <= 3'd1) begin
               state_d = ST_ACTIVE;
               cnt_d   = 3'(ACTIVE_CYC);
`ifdef IDE_IORDY_EN
               wait_d  = '0;
`endif
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         ST_ACTIVE: begin
            if (bus.AS_n) begin
               if (RECOV_CYC != 0) begin
                  state_d = ST_RECOVER;
                  cnt_d   = 3'(RECOV_CYC);
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (cnt_q > 3'd1) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
`ifdef IDE_IORDY_EN
               // Device stretches the strobe with IORDY low; give up after WAIT_MAX cycles.
               if (bus.IDE_IORDY) begin
                  state_d = ST_TERM;
               end else if (32'(wait_q) + 32'd1 >= WAIT_MAX) begin
                  state_d = ST_TERM;
                  tmo_d   = 1'b1;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
`else
               state_d = ST_TERM;
`endif
            end
         end

         ST_ROMRD: begin
            if (bus.AS_n) begin
               state_d = ST_IDLE;
            end else if (cnt_q <= 3'd1) begin
               state_d = ST_TERM;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         ST_TERM: begin
            if (bus.AS_n) begin
               if (ide_q && (RECOV_CYC != 0)) begin
                  state_d = ST_RECOVER;
                  cnt_d   = 3'(RECOV_CYC);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_RECOVER: begin
            if (cnt_q <= 3'd1) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs decoded from the next state so they are valid right after the edge.
      cs0_n_d    = 1'b1;
      cs1_n_d    = 1'b1;
      ior_n_d    = 1'b1;
      iow_n_d    = 1'b1;
      rom_oe_n_d = 1'b1;
      buf_oe_n_d = 1'b1;
      buf_dir_d  = 1'b0;
      dtack_d    = (state_d == ST_TERM);

      if (ide_d) begin
         if (state_d inside {ST_SETUP, ST_ACTIVE, ST_TERM, ST_RECOVER}) begin
            cs0_n_d = a12_d;
            cs1_n_d = ~a12_d;
         end
         if (state_d inside {ST_SETUP, ST_ACTIVE, ST_TERM}) begin
            buf_oe_n_d = 1'b0;
            buf_dir_d  = rw_d;
         end
         if (state_d inside {ST_ACTIVE, ST_TERM}) begin
            ior_n_d = ~rw_d;
            iow_n_d = rw_d;
         end
      end else if (rw_d && (state_d inside {ST_ROMRD, ST_TERM})) begin
         rom_oe_n_d = 1'b0;
         buf_oe_n_d = 1'b0;
         buf_dir_d  = 1'b1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         ide_q      <= 1'b0;
         a12_q      <= 1'b0;
         rw_q       <= 1'b0;
         cs0_n_q    <= 1'b1;
         cs1_n_q    <= 1'b1;
         ior_n_q    <= 1'b1;
         iow_n_q    <= 1'b1;
         rom_oe_n_q <= 1'b1;
         buf_oe_n_q <= 1'b1;
         buf_dir_q  <= 1'b0;
         dtack_q    <= 1'b0;
`ifdef IDE_IORDY_EN
         wait_q     <= '0;
         tmo_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ide_q      <= ide_d;
         a12_q      <= a12_d;
         rw_q       <= rw_d;
         cs0_n_q    <= cs0_n_d;
         cs1_n_q    <= cs1_n_d;
         ior_n_q    <= ior_n_d;
         iow_n_q    <= iow_n_d;
         rom_oe_n_q <= rom_oe_n_d;
         buf_oe_n_q <= buf_oe_n_d;
         buf_dir_q  <= buf_dir_d;
         dtack_q    <= dtack_d;
`ifdef IDE_IORDY_EN
         wait_q     <= wait_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

   assign bus.IDE_CS0_n = cs0_n_q;
   assign bus.IDE_CS1_n = cs1_n_q;
   assign bus.IDE_IOR_n = ior_n_q;
   assign bus.IDE_IOW_n = iow_n_q;
   assign bus.ROM_OE_n  = rom_oe_n_q;
   assign bus.BUF_OE_n  = buf_oe_n_q;
   assign bus.BUF_DIR   = buf_dir_q;

   // dtack drops the instant the CPU releases AS_n, without waiting for an edge.
   assign bus.dtack     = dtack_q & ~bus.AS_n;

`ifdef IDE_IORDY_EN
   assign bus.iordy_tmo = tmo_q;
`else
   logic unused_iordy;
   assign unused_iordy  = bus.IDE_IORDY | (WAIT_MAX == 0);
   assign bus.iordy_tmo = 1'b0;
`endif

endmodule
